fetch_stage: RTL

// - Instruction fetch stage plus IF/ID register. It feeds the decode stage instrD, pcD and pcplusfourD.
// - Keeps the fetch PC and issues single-outstanding reads to instruction memory (variable latency).
// - Buffers returned words in a small prefetch FIFO.
// - Honours decode stall and execute-stage redirects (branch/jump target).

---
 rtl/fetch_stage.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with the IF/ID pipeline register.
//   * Holds the fetch PC and issues at most one outstanding read to a
//     variable-latency instruction memory.
//   * Returned words are buffered together with their PC in a small
//     prefetch FIFO (BUF_DEPTH entries, power of two, >= 2).
//   * The IF/ID register pops the FIFO when decode is not stalled.
//   * An execute-stage redirect (pcsrcE) overrides everything: it reloads
//     the fetch PC, flushes the FIFO and the IF/ID register, and causes any
//     read still in flight to be discarded when it returns.
//
// Configuration macro:
//   FETCH_BUBBLE_NOP_EN  defined   -> bubble instruction is 32'h0000_0013
//                                     (addi x0,x0,0)
//                        undefined -> bubble instruction is 32'h0000_0000
//
// Ports:
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   one-cycle read request pulse
//   imem_addr    out  32  read address, valid while imem_req=1
//   imem_valid   in   1   read response strobe
//   imem_rdata   in   32  read data, valid with imem_valid
//   stallD       in   1   decode stall: hold IF/ID outputs
//   pcsrcE       in   1   redirect request from execute
//   pctargetE    in   32  redirect target
//   instrD       out  32  instruction to decode
//   pcD          out  32  PC of instrD
//   pcplusfourD  out  32  pcD + 4
//   validD       out  1   instrD holds a real fetched instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stallD,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplusfourD,
    output logic        validD
);

`ifdef FETCH_BUBBLE_NOP_EN
    localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
    localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      fetch_pc_reg;
    logic [31:0]      issued_pc_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;

    // Each FIFO entry is {pc, instruction}.
    logic [63:0]      fifo_mem [BUF_DEPTH];
    logic [63:0]      head;

    logic             issue;
    logic             push;
    logic             pop;

    logic             valid_d_reg;
    logic [31:0]      instr_d_reg;
    logic [31:0]      pc_d_reg;
    logic [31:0]      pc4_d_reg;

    // -------------------------------------------------------------------------
    // Fetch FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        push       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Registered count is used, so a full FIFO can never be
                // overrun by the single outstanding read.
                if (!pcsrcE && (count_reg < FULL_CNT)) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    // A redirect in the same cycle kills the returning word.
                    push       = !pcsrcE;
                    state_next = S_IDLE;
                end else if (pcsrcE) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The FSM resets into IDLE, which would otherwise show a request while
    // rst_n is still held low.
    assign imem_req  = issue & rst_n;
    assign imem_addr = fetch_pc_reg;

    // -------------------------------------------------------------------------
    // Fetch PC and PC of the outstanding read
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg  <= RESET_PC;
            issued_pc_reg <= '0;
        end else begin
            if (pcsrcE) begin
                fetch_pc_reg <= pctargetE;
            end else if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            if (issue) begin
                issued_pc_reg <= fetch_pc_reg;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Prefetch FIFO
    // -------------------------------------------------------------------------
    assign pop        = !pcsrcE && !stallD && (count_reg != '0);
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign head       = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (pcsrcE) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // Pointers wrap naturally because BUF_DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage has no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {issued_pc_reg, imem_rdata};
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d_reg <= 1'b0;
            instr_d_reg <= BUBBLE;
            pc_d_reg    <= '0;
            pc4_d_reg   <= '0;
        end else if (pcsrcE) begin
            // Redirect wins over stallD; pcD/pcplusfourD are don't-care
            // while validD=0 and simply hold.
            valid_d_reg <= 1'b0;
            instr_d_reg <= BUBBLE;
        end else if (!stallD) begin
            if (pop) begin
                valid_d_reg <= 1'b1;
                instr_d_reg <= head[31:0];
                pc_d_reg    <= head[63:32];
                pc4_d_reg   <= head[63:32] + 32'd4;
            end else begin
                valid_d_reg <= 1'b0;
                instr_d_reg <= BUBBLE;
            end
        end
    end

    assign validD      = valid_d_reg;
    assign instrD      = instr_d_reg;
    assign pcD         = pc_d_reg;
    assign pcplusfourD = pc4_d_reg;

endmodule
